// File: rtl/ro_scan_uart_top_if.sv
// Control/result bundle between a host and the ring-oscillator scanner.
//   start, continuous, ch_mask : host -> scanner (scan request, channel enables)
//   busy, count_valid          : scanner -> host (scan in progress, result strobe)
//   last_ch, last_count        : scanner -> host (latest channel result)
interface ro_scan_uart_top_if #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 16
);
   logic              start;
   logic              continuous;
   logic [N_CH-1:0]   ch_mask;
   logic              busy;
   logic              count_valid;
   logic [3:0]        last_ch;
   logic [CNT_W-1:0]  last_count;

   modport master (
      output start, continuous, ch_mask,
      input  busy, count_valid, last_ch, last_count
   );

   modport slave (
      input  start, continuous, ch_mask,
      output busy, count_valid, last_ch, last_count
   );
endinterface

// File: rtl/ro_scan_uart_top.sv
// Ring-oscillator frequency scanner with UART reporting.
// Counts rising edges of each enabled RO channel over a fixed gate window,
// scanning channels round-robin, and sends each result as an 8N1 frame:
// header 0xA0|ch, then the count MSB-first padded to whole bytes.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   ro_in : asynchronous ring-oscillator outputs, one per channel
//   txd   : UART serial output, idles high
//   ctl   : scan control and result bundle (slave side)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start/continuous with a non-zero channel mask
// S_GATE  | counting edges of cur_ch for GATE_CYCLES clocks
// S_LATCH | one cycle: result published, count_valid high, frame loaded
// S_TX    | shifting the frame out on txd, then pick next channel
module ro_scan_uart_top #(
   parameter int N_CH        = 4,
   parameter int CNT_W       = 16,
   parameter int GATE_CYCLES = 100000,
   parameter int BAUD_DIV    = 868,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] ro_in,
   output logic            txd,
   ro_scan_uart_top_if.slave ctl
);

   localparam int NB     = (CNT_W + 7) / 8;
   localparam int PAD_W  = NB * 8;
   localparam int GATE_W = $clog2(GATE_CYCLES + 1);
   localparam int BAUD_W = $clog2(BAUD_DIV + 1);
   localparam int BYTE_W = $clog2(NB + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GATE  = 2'd1;
   localparam logic [1:0] S_LATCH = 2'd2;
   localparam logic [1:0] S_TX    = 2'd3;

   logic [1:0]        state_q;
   logic [N_CH-1:0]   sync_q [SYNC_STAGES];
   logic [N_CH-1:0]   ro_prev_q;
   logic [N_CH-1:0]   edge_vec;
   logic [N_CH-1:0]   mask_q;
   logic [3:0]        cur_ch_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_inc;
   logic [GATE_W-1:0] gate_q;
   logic [BAUD_W-1:0] baud_q;
   logic [3:0]        bit_q;
   logic [BYTE_W-1:0] byte_q;
   logic [9:0]        shreg_q;
   logic [PAD_W-1:0]  frame_q;
   logic [3:0]        last_ch_q;
   logic [CNT_W-1:0]  last_count_q;
   logic [3:0]        low_new;
   logic [3:0]        nxt_ch;
   logic              nxt_ok;
   logic              edge_sel;

   // Synchroniser chain; the extra ro_prev_q flop turns the synchronised
   // level into a one-cycle rising-edge pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         ro_prev_q <= '0;
      end else begin
         sync_q[0] <= ro_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         ro_prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign edge_vec = sync_q[SYNC_STAGES-1] & ~ro_prev_q;

   // Downward loops so the last hit is the lowest qualifying channel.
   always_comb begin
      low_new  = '0;
      nxt_ch   = '0;
      nxt_ok   = 1'b0;
      edge_sel = 1'b0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (ctl.ch_mask[i]) low_new = 4'(i);
         if (mask_q[i] && (4'(i) > cur_ch_q)) begin
            nxt_ch = 4'(i);
            nxt_ok = 1'b1;
         end
         if (4'(i) == cur_ch_q) edge_sel = edge_vec[i];
      end
   end

   assign cnt_inc = (edge_sel && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         mask_q       <= '0;
         cur_ch_q     <= '0;
         cnt_q        <= '0;
         gate_q       <= '0;
         baud_q       <= '0;
         bit_q        <= '0;
         byte_q       <= '0;
         shreg_q      <= '1;
         frame_q      <= '0;
         last_ch_q    <= '0;
         last_count_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if ((ctl.start || ctl.continuous) && (ctl.ch_mask != '0)) begin
                  mask_q   <= ctl.ch_mask;
                  cur_ch_q <= low_new;
                  cnt_q    <= '0;
                  gate_q   <= GATE_W'(GATE_CYCLES - 1);
                  state_q  <= S_GATE;
               end
            end
            S_GATE: begin
               cnt_q <= cnt_inc;
               if (gate_q == '0) begin
                  // cnt_inc already includes this final gate cycle's edge
                  last_ch_q    <= cur_ch_q;
                  last_count_q <= cnt_inc;
                  frame_q      <= PAD_W'(cnt_inc);
                  state_q      <= S_LATCH;
               end else begin
                  gate_q <= gate_q - GATE_W'(1);
               end
            end
            S_LATCH: begin
               shreg_q <= {1'b1, 4'hA, cur_ch_q, 1'b0};
               byte_q  <= BYTE_W'(NB);
               bit_q   <= 4'd9;
               baud_q  <= BAUD_W'(BAUD_DIV - 1);
               state_q <= S_TX;
            end
            S_TX: begin
               if (baud_q != '0) begin
                  baud_q <= baud_q - BAUD_W'(1);
               end else begin
                  baud_q <= BAUD_W'(BAUD_DIV - 1);
                  if (bit_q != 4'd0) begin
                     shreg_q <= {1'b1, shreg_q[9:1]};
                     bit_q   <= bit_q - 4'd1;
                  end else if (byte_q != '0) begin
                     // next byte follows the stop bit with no idle gap
                     shreg_q <= {1'b1, frame_q[PAD_W-1 -: 8], 1'b0};
                     frame_q <= frame_q << 8;
                     byte_q  <= byte_q - BYTE_W'(1);
                     bit_q   <= 4'd9;
                  end else begin
                     shreg_q <= '1;
                     if (nxt_ok) begin
                        cur_ch_q <= nxt_ch;
                        cnt_q    <= '0;
                        gate_q   <= GATE_W'(GATE_CYCLES - 1);
                        state_q  <= S_GATE;
                     end else if (ctl.continuous && (ctl.ch_mask != '0)) begin
                        mask_q   <= ctl.ch_mask;
                        cur_ch_q <= low_new;
                        cnt_q    <= '0;
                        gate_q   <= GATE_W'(GATE_CYCLES - 1);
                        state_q  <= S_GATE;
                     end else begin
                        state_q <= S_IDLE;
                     end
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // shreg_q is all ones outside a frame, so txd idles high from a register
   assign txd             = shreg_q[0];
   assign ctl.busy        = (state_q != S_IDLE);
   assign ctl.count_valid = (state_q == S_LATCH);
   assign ctl.last_ch     = last_ch_q;
   assign ctl.last_count  = last_count_q;

endmodule

// File: tb/tb_ro_scan_uart_top.sv
// Directed bench for ro_scan_uart_top: a 16-bit-count instance and an
// 8-bit-count instance (saturation), RO square waves from a cycle counter,
// a UART receiver that also checks bit width and back-to-back bytes.
module tb_ro_scan_uart_top;

   localparam int BAUD = 4;

   logic       clk = 1'b0;
   logic       rst_m, rst_s;
   logic [3:0] ro_m, ro_s;
   logic       txd_m, txd_s;
   int         per_m [4];
   int         per_s;
   int         cyc = 0;

   int n_chk  = 0;
   int n_pass = 0;

   logic [3:0]  q_ch  [$];
   int          q_cnt [$];
   logic [7:0]  rx_b  [4];

   always #5 clk = ~clk;

   ro_scan_uart_top_if #(.N_CH(4), .CNT_W(16)) ifm ();
   ro_scan_uart_top_if #(.N_CH(4), .CNT_W(8))  ifs ();

   ro_scan_uart_top #(.N_CH(4), .CNT_W(16), .GATE_CYCLES(1000), .BAUD_DIV(BAUD), .SYNC_STAGES(2))
      u_dut (.clk(clk), .rst(rst_m), .ro_in(ro_m), .txd(txd_m), .ctl(ifm));

   ro_scan_uart_top #(.N_CH(4), .CNT_W(8), .GATE_CYCLES(4000), .BAUD_DIV(BAUD), .SYNC_STAGES(2))
      u_sat (.clk(clk), .rst(rst_s), .ro_in(ro_s), .txd(txd_s), .ctl(ifs));

   always @(negedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 4; i++)
         ro_m[i] <= (per_m[i] == 0) ? 1'b0 : ((cyc % per_m[i]) < (per_m[i] / 2));
      ro_s[0]   <= (per_s == 0) ? 1'b0 : ((cyc % per_s) < (per_s / 2));
      ro_s[3:1] <= 3'b000;
   end

   always @(negedge clk) begin
      if (ifm.count_valid === 1'b1) begin
         q_ch.push_back(ifm.last_ch);
         q_cnt.push_back(int'(ifm.last_count));
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic txd_of(input bit sat);
      return sat ? txd_s : txd_m;
   endfunction

   // Called on a negedge. Samples every bit near its start and near its end,
   // so a bit that is not exactly BAUD cycles wide shows up as ok=0.
   task automatic recv_byte(input bit sat, input int max_wait, output logic [7:0] b, output bit ok);
      int   w;
      logic a, c;
      b  = '0;
      ok = 1'b1;
      w  = 0;
      while (txd_of(sat) !== 1'b0 && w < max_wait) begin
         @(negedge clk);
         w++;
      end
      if (txd_of(sat) !== 1'b0) begin
         ok = 1'b0;
         return;
      end
      for (int k = 0; k < 10; k++) begin
         a = txd_of(sat);
         repeat (BAUD - 1) @(negedge clk);
         c = txd_of(sat);
         if (a !== c) ok = 1'b0;
         if (k == 0 && a !== 1'b0) ok = 1'b0;
         if (k >= 1 && k <= 8) b[k-1] = a;
         if (k == 9 && a !== 1'b1) ok = 1'b0;
         if (k < 9) @(negedge clk);
      end
   endtask

   task automatic recv_frame(input bit sat, input int nbytes, input int first_wait, input bit drop_cont);
      bit         ok;
      logic [7:0] b;
      for (int i = 0; i < nbytes; i++) begin
         recv_byte(sat, (i == 0) ? first_wait : 1, b, ok);
         rx_b[i] = b;
         check("rx_byte_ok", ok, 1);
         if (i == 0 && drop_cont) ifm.continuous = 1'b0;
      end
   endtask

   task automatic check_frame16(input logic [7:0] hdr, input logic [15:0] cnt);
      check("frame_hdr", rx_b[0], hdr);
      check("frame_msb", rx_b[1], cnt[15:8]);
      check("frame_lsb", rx_b[2], cnt[7:0]);
   endtask

   task automatic check_res(input int idx, input logic [3:0] ch, input int cnt);
      if (q_ch.size() > idx) begin
         check("res_ch", q_ch[idx], ch);
         check("res_cnt", q_cnt[idx], cnt);
      end else begin
         check("res_present", q_ch.size(), idx + 1);
      end
   endtask

   task automatic quiet(input int n, output int bad);
      bad = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (txd_m !== 1'b1 || ifm.busy !== 1'b0) bad++;
      end
   endtask

   task automatic pulse_start_m();
      ifm.start = 1'b1;
      @(negedge clk);
      ifm.start = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         qb, bad;
      bit         ok;
      logic [7:0] b;

      rst_m = 1'b1;  rst_s = 1'b1;
      ifm.start = 1'b0; ifm.continuous = 1'b0; ifm.ch_mask = 4'b0000;
      ifs.start = 1'b0; ifs.continuous = 1'b0; ifs.ch_mask = 4'b0000;
      for (int i = 0; i < 4; i++) per_m[i] = 0;
      per_s = 0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_txd",   txd_m, 1);
      check("rst_busy",  ifm.busy, 0);
      check("rst_cv",    ifm.count_valid, 0);
      check("rst_ch",    ifm.last_ch, 0);
      check("rst_count", ifm.last_count, 0);
      check("rst_txd_s", txd_s, 1);
      rst_m = 1'b0;  rst_s = 1'b0;
      @(negedge clk);

      // basic count: period 10 over 1000 cycles -> 100
      per_m[0] = 10;
      ifm.ch_mask = 4'b0001;
      repeat (20) @(negedge clk);
      qb = q_ch.size();
      pulse_start_m();
      check("busy_go", ifm.busy, 1);
      recv_frame(0, 3, 1200, 0);
      check_frame16(8'hA0, 16'd100);
      check("busy_in_stop", ifm.busy, 1);
      @(negedge clk);
      check("busy_fall", ifm.busy, 0);
      check("basic_nres", q_ch.size(), qb + 1);
      check_res(qb, 4'd0, 100);

      // mask skip: channels 1 (period 8) and 3 (period 20)
      per_m[1] = 8; per_m[2] = 6; per_m[3] = 20;
      ifm.ch_mask = 4'b1010;
      repeat (20) @(negedge clk);
      qb = q_ch.size();
      pulse_start_m();
      recv_frame(0, 3, 1200, 0);
      check_frame16(8'hA1, 16'd125);
      recv_frame(0, 3, 1200, 0);
      check_frame16(8'hA3, 16'd50);
      @(negedge clk);
      check("skip_idle", ifm.busy, 0);
      check("skip_nres", q_ch.size(), qb + 2);
      check_res(qb, 4'd1, 125);
      check_res(qb + 1, 4'd3, 50);

      // saturation on the 8-bit instance: 500 edges clamp to 0xFF
      per_s = 8;
      ifs.ch_mask = 4'b0001;
      repeat (20) @(negedge clk);
      ifs.start = 1'b1;
      @(negedge clk);
      ifs.start = 1'b0;
      recv_frame(1, 2, 4200, 0);
      check("sat_hdr", rx_b[0], 8'hA0);
      check("sat_byte", rx_b[1], 8'hFF);
      check("sat_last_count", ifs.last_count, 8'hFF);
      check("sat_last_ch", ifs.last_ch, 0);
      @(negedge clk);
      check("sat_idle", ifs.busy, 0);

      // continuous wrap 0,1,0,1 then drop continuous during channel 1 TX
      ifm.ch_mask = 4'b0011;
      repeat (20) @(negedge clk);
      qb = q_ch.size();
      ifm.continuous = 1'b1;
      recv_frame(0, 3, 1200, 0);
      check_frame16(8'hA0, 16'd100);
      recv_frame(0, 3, 1200, 0);
      check_frame16(8'hA1, 16'd125);
      recv_frame(0, 3, 1200, 0);
      check_frame16(8'hA0, 16'd100);
      recv_frame(0, 3, 1200, 1);
      check_frame16(8'hA1, 16'd125);
      quiet(1500, bad);
      check("cont_stop_quiet", bad, 0);
      check("cont_nres", q_ch.size(), qb + 4);
      check_res(qb,     4'd0, 100);
      check_res(qb + 1, 4'd1, 125);
      check_res(qb + 2, 4'd0, 100);
      check_res(qb + 3, 4'd1, 125);

      // reset during a data bit of byte 1
      ifm.ch_mask = 4'b0001;
      qb = q_ch.size();
      pulse_start_m();
      recv_byte(0, 1200, b, ok);
      check("rstmid_hdr_ok", ok, 1);
      check("rstmid_hdr", b, 8'hA0);
      repeat (10) @(negedge clk);
      check("rstmid_txd_data_bit", txd_m, 1'b0);
      rst_m = 1'b1;
      @(negedge clk);
      rst_m = 1'b0;
      check("rstmid_txd", txd_m, 1);
      check("rstmid_busy", ifm.busy, 0);
      quiet(1500, bad);
      check("rstmid_quiet", bad, 0);
      check("rstmid_nres", q_ch.size(), qb + 1);
      pulse_start_m();
      recv_frame(0, 3, 1200, 0);
      check_frame16(8'hA0, 16'd100);
      check("rstmid_rescan_nres", q_ch.size(), qb + 2);
      check_res(qb + 1, 4'd0, 100);

      // empty mask: start ignored
      @(negedge clk);
      ifm.ch_mask = 4'b0000;
      pulse_start_m();
      quiet(50, bad);
      check("mask0_quiet", bad, 0);

      // start while busy: one frame only
      ifm.ch_mask = 4'b0001;
      qb = q_ch.size();
      pulse_start_m();
      repeat (100) @(negedge clk);
      check("busy_before_2nd_start", ifm.busy, 1);
      pulse_start_m();
      recv_frame(0, 3, 1200, 0);
      check_frame16(8'hA0, 16'd100);
      quiet(1500, bad);
      check("busy_start_quiet", bad, 0);
      check("busy_start_nres", q_ch.size(), qb + 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ro_scan_uart_top.md
Name: ro_scan_uart_top

Overview:
- Parametrised successor to the single-sensor ring-oscillator test top.
- Measures the frequency of N_CH asynchronous ring-oscillator outputs. Each channel's rising edges are counted over a fixed gate window of system clocks; channels are scanned round-robin.
- Each result is sent as a framed record on an 8N1 UART txd line.
- Sits at FPGA top level between the RO array and the board UART pin. It replaces the separate PLL, clock divider and sensor wrapper with one clock domain.

Parameters:
- N_CH, 4, number of RO channels (1..16).
- CNT_W, 16, edge-counter width (8..32).
- GATE_CYCLES, 100000, gate window length in clk cycles (>=2).
- BAUD_DIV, 868, clk cycles per UART bit (100 MHz / 115200).
- SYNC_STAGES, 2, synchroniser flops per RO input (>=2).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous active-high reset.
- ro_in  in  N_CH  asynchronous RO outputs, one bit per channel.
- ch_mask  in  N_CH  1 = channel enabled; latched at scan start.
- start  in  1  single-cycle pulse: run one scan of all enabled channels.
- continuous  in  1  while high, scans repeat without needing start.
- txd  out  1  UART serial output, idle high.
- busy  out  1  high from scan start until the FSM returns to IDLE.
- count_valid  out  1  one-cycle pulse when a channel result is latched.
- last_ch  out  4  channel index of the latest result.
- last_count  out  CNT_W  count of the latest result.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values: txd=1, busy=0, count_valid=0, last_ch=0, last_count=0; FSM in IDLE; synchronisers and counters cleared.
- rst asserted mid-operation (including mid-bit) aborts everything. txd is 1 on the cycle after rst is sampled. No partial frame is resumed.
- Input path:
  - Each ro_in bit passes through a SYNC_STAGES flop chain.
  - A rising edge is detected when the last stage is 1 and the stage before it was 0.
  - Input frequency must be < clk/4. Higher frequencies alias and are out of spec.
- FSM states: IDLE, GATE, LATCH, TX.
- IDLE:
  - Leaves IDLE when (start || continuous) && ch_mask != 0.
  - On leaving: latch ch_mask, select the lowest enabled channel, clear the counter, busy=1, go to GATE.
  - If ch_mask == 0, start is ignored and busy stays 0.
- GATE:
  - Lasts exactly GATE_CYCLES cycles. Edges detected in those cycles on the selected channel increment the counter.
  - The counter saturates at 2^CNT_W-1 and does not wrap.
- LATCH (1 cycle): last_ch and last_count are updated and count_valid=1 in the same cycle. Then go to TX.
- TX: sends a frame of 1 + NB bytes, where NB = ceil(CNT_W/8).
  - Byte 0 = 0xA0 | ch.
  - Then the count MSB-first, zero-padded to NB*8 bits.
  - Each byte: start bit 0, 8 data bits LSB-first, stop bit 1, each bit held exactly BAUD_DIV cycles.
  - No idle gap between bytes.
- After the last stop bit completes, choose the next channel:
  - Next enabled channel above the current one: go to GATE (counter cleared).
  - Otherwise, if continuous=1: re-latch ch_mask, go to the lowest enabled channel and GATE. If the new mask is 0, go to IDLE.
  - Otherwise: IDLE, busy=0 in the same cycle the FSM enters IDLE.
- start pulses while busy=1 are ignored. ch_mask changes while busy=1 take effect only at the next scan start or wrap.
- Edges on non-selected channels are never counted. The RO edges that arrive during LATCH or TX are not counted.
- Simultaneous start and rst: rst wins.

Test Plan:
- Basic count: N_CH=4, GATE_CYCLES=1000, BAUD_DIV=4, ch_mask=0001, ro_in[0] square wave with period 10 clk, pulse start.
  - Required: one count_valid with last_ch=0 and last_count in {99,100}.
  - Required: txd frame A0 00 64 (for 100), each bit 4 cycles.
  - Required: busy falls after the final stop bit.
- Mask skip: ch_mask=1010, distinct periods on ro_in[1] (8 clk) and ro_in[3] (20 clk).
  - Required: exactly two results, channels 1 then 3, counts ~125 and ~50.
  - Required: headers A1 and A3; no gate is run for channels 0 and 2.
- Saturation: CNT_W=8, GATE_CYCLES=4000, ro period 8 clk.
  - Required: last_count=0xFF and frame A0 FF.
- Continuous wrap: continuous=1, ch_mask=0011.
  - Required: results in order 0,1,0,1...
  - Then drop continuous during channel 1 TX → FSM goes to IDLE after that frame; busy=0.
- Reset mid-frame: assert rst for 1 cycle during a data bit of byte 1.
  - Required: txd=1 and busy=0 the next cycle; no further count_valid; a subsequent start runs a clean scan.
- Edge cases:
  - ch_mask=0 with start → busy stays 0, txd stays 1.
  - start pulsed while busy=1 → no extra frame.
